// File: rtl/xbus_mcast_ctrl.sv
// Row-bus controller: flush-time row configuration, per-channel FIFOs, column multicast
// delivery with all-or-nothing valid/ready handshake towards the PE columns.

module xbus_mcast_chan #(
  parameter int W          = 16,
  parameter int NUM_COL    = 4,
  parameter int YW         = 2,
  parameter int XW         = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               run,
  input  logic               flush,
  input  logic [YW-1:0]      row_id,
  input  logic               g2b_valid,
  input  logic [W-1:0]       g2b_data,
  input  logic [YW-1:0]      g2b_ytag,
  input  logic [XW-1:0]      g2b_xid,
  input  logic               g2b_xbcast,
  output logic               g2b_ready,
  output logic               b2m_valid,
  output logic [W-1:0]       b2m_data,
  output logic [NUM_COL-1:0] b2m_col_en,
  input  logic [NUM_COL-1:0] b2m_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]       data_mem [FIFO_DEPTH];
  logic [NUM_COL-1:0] col_mem  [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               match, full, push, pop;
  logic [NUM_COL-1:0] col_en_in;

  // Out-of-range xid without broadcast yields an all-zero mask, which is dropped at the head.
  always_comb begin
    col_en_in = '0;
    for (int i = 0; i < NUM_COL; i++)
      col_en_in[i] = g2b_xbcast | (32'(g2b_xid) == i);
  end

  assign match      = g2b_valid && (g2b_ytag == row_id);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign g2b_ready  = run && (!match || !full);
  assign push       = match && g2b_ready;
  assign b2m_valid  = (count != '0);
  assign pop        = b2m_valid && (&(~col_mem[rd_ptr] | b2m_ready));
  assign b2m_data   = b2m_valid ? data_mem[rd_ptr] : '0;
  assign b2m_col_en = b2m_valid ? col_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_mem[wr_ptr] <= g2b_data;
      col_mem[wr_ptr]  <= col_en_in;
    end
  end
endmodule

module xbus_mcast_ctrl #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_COL    = 4,
  parameter  int NUM_ROW    = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int YW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1,
  localparam int XW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic [YW-1:0]           cfg_row_id,
  input  logic [7:0]              kernel_size,
  output logic                    rst_busy,
  output logic [7:0]              kernel_size_o,

  input  logic                    ifmap_g2b_valid,
  input  logic [DATA_WIDTH-1:0]   ifmap_g2b_data,
  input  logic [YW-1:0]           ifmap_g2b_ytag,
  input  logic [XW-1:0]           ifmap_g2b_xid,
  input  logic                    ifmap_g2b_xbcast,
  output logic                    ifmap_g2b_ready,
  output logic                    ifmap_b2m_valid,
  output logic [DATA_WIDTH-1:0]   ifmap_b2m_data,
  output logic [NUM_COL-1:0]      ifmap_b2m_col_en,
  input  logic [NUM_COL-1:0]      ifmap_b2m_ready,

  input  logic                    fltr_g2b_valid,
  input  logic [DATA_WIDTH-1:0]   fltr_g2b_data,
  input  logic [YW-1:0]           fltr_g2b_ytag,
  input  logic [XW-1:0]           fltr_g2b_xid,
  input  logic                    fltr_g2b_xbcast,
  output logic                    fltr_g2b_ready,
  output logic                    fltr_b2m_valid,
  output logic [DATA_WIDTH-1:0]   fltr_b2m_data,
  output logic [NUM_COL-1:0]      fltr_b2m_col_en,
  input  logic [NUM_COL-1:0]      fltr_b2m_ready,

  input  logic                    psum_g2b_valid,
  input  logic [2*DATA_WIDTH-1:0] psum_g2b_data,
  input  logic [YW-1:0]           psum_g2b_ytag,
  input  logic [XW-1:0]           psum_g2b_xid,
  input  logic                    psum_g2b_xbcast,
  output logic                    psum_g2b_ready,
  output logic                    psum_b2m_valid,
  output logic [2*DATA_WIDTH-1:0] psum_b2m_data,
  output logic [NUM_COL-1:0]      psum_b2m_col_en,
  input  logic [NUM_COL-1:0]      psum_b2m_ready
);
  typedef enum logic [1:0] {UNCFG, FLUSH, RUN} state_t;

  state_t        state;
  logic          flush_cnt;
  logic [YW-1:0] row_id_q;
  logic          run;

  // A flush in any state (re)enters FLUSH and restarts the two-cycle settle window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= UNCFG;
      flush_cnt     <= 1'b0;
      rst_busy      <= 1'b1;
      row_id_q      <= '0;
      kernel_size_o <= '0;
    end else if (flush) begin
      state         <= FLUSH;
      flush_cnt     <= 1'b0;
      rst_busy      <= 1'b1;
      row_id_q      <= cfg_row_id;
      kernel_size_o <= kernel_size;
    end else if (state == FLUSH) begin
      flush_cnt <= 1'b1;
      if (flush_cnt) begin
        state    <= RUN;
        rst_busy <= 1'b0;
      end
    end
  end

  assign run = (state == RUN);

  xbus_mcast_chan #(.W(DATA_WIDTH), .NUM_COL(NUM_COL), .YW(YW), .XW(XW), .FIFO_DEPTH(FIFO_DEPTH))
  u_ifmap (
    .clk(clk), .rstn(rstn), .run(run), .flush(flush), .row_id(row_id_q),
    .g2b_valid(ifmap_g2b_valid), .g2b_data(ifmap_g2b_data), .g2b_ytag(ifmap_g2b_ytag),
    .g2b_xid(ifmap_g2b_xid), .g2b_xbcast(ifmap_g2b_xbcast), .g2b_ready(ifmap_g2b_ready),
    .b2m_valid(ifmap_b2m_valid), .b2m_data(ifmap_b2m_data), .b2m_col_en(ifmap_b2m_col_en),
    .b2m_ready(ifmap_b2m_ready)
  );

  xbus_mcast_chan #(.W(DATA_WIDTH), .NUM_COL(NUM_COL), .YW(YW), .XW(XW), .FIFO_DEPTH(FIFO_DEPTH))
  u_fltr (
    .clk(clk), .rstn(rstn), .run(run), .flush(flush), .row_id(row_id_q),
    .g2b_valid(fltr_g2b_valid), .g2b_data(fltr_g2b_data), .g2b_ytag(fltr_g2b_ytag),
    .g2b_xid(fltr_g2b_xid), .g2b_xbcast(fltr_g2b_xbcast), .g2b_ready(fltr_g2b_ready),
    .b2m_valid(fltr_b2m_valid), .b2m_data(fltr_b2m_data), .b2m_col_en(fltr_b2m_col_en),
    .b2m_ready(fltr_b2m_ready)
  );

  xbus_mcast_chan #(.W(2*DATA_WIDTH), .NUM_COL(NUM_COL), .YW(YW), .XW(XW), .FIFO_DEPTH(FIFO_DEPTH))
  u_psum (
    .clk(clk), .rstn(rstn), .run(run), .flush(flush), .row_id(row_id_q),
    .g2b_valid(psum_g2b_valid), .g2b_data(psum_g2b_data), .g2b_ytag(psum_g2b_ytag),
    .g2b_xid(psum_g2b_xid), .g2b_xbcast(psum_g2b_xbcast), .g2b_ready(psum_g2b_ready),
    .b2m_valid(psum_b2m_valid), .b2m_data(psum_b2m_data), .b2m_col_en(psum_b2m_col_en),
    .b2m_ready(psum_b2m_ready)
  );
endmodule

// File: tb/tb_xbus_mcast_ctrl.sv
// Scoreboard bench for xbus_mcast_ctrl: a predictor queues expected words per channel,
// a monitor pops and compares them against what the DUT presents on b2m.

module tb_xbus_mcast_ctrl;
  localparam int DW = 16, NC = 4, NR = 4, DEPTH = 4, YW = 2, XW = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          flush = 1'b0;
  logic [YW-1:0] cfg_row_id = '0;
  logic [7:0]    kernel_size = '0;
  wire           rst_busy;
  wire  [7:0]    kernel_size_o;

  logic          gv [3];
  logic [31:0]   gd [3];
  logic [YW-1:0] gy [3];
  logic [XW-1:0] gx [3];
  logic          gb [3];
  logic [NC-1:0] br [3];

  wire           if_gr, fl_gr, ps_gr, if_bv, fl_bv, ps_bv;
  wire  [15:0]   if_bd, fl_bd;
  wire  [31:0]   ps_bd;
  wire  [NC-1:0] if_bc, fl_bc, ps_bc;

  logic          gr [3];
  logic          bv [3];
  logic [31:0]   bd [3];
  logic [NC-1:0] bc [3];

  typedef logic [35:0] ent_t;
  ent_t q0[$], q1[$], q2[$];

  string chn [3] = '{"ifmap", "fltr", "psum"};
  int errors = 0;
  int checks = 0;

  logic [YW-1:0] m_row = '0;
  logic [7:0]    m_kernel = '0;
  int            m_left = 0;
  bit            m_run = 0;
  logic [YW-1:0] row = '0;

  xbus_mcast_ctrl #(.DATA_WIDTH(DW), .NUM_COL(NC), .NUM_ROW(NR), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .cfg_row_id(cfg_row_id), .kernel_size(kernel_size),
    .rst_busy(rst_busy), .kernel_size_o(kernel_size_o),
    .ifmap_g2b_valid(gv[0]), .ifmap_g2b_data(gd[0][15:0]), .ifmap_g2b_ytag(gy[0]),
    .ifmap_g2b_xid(gx[0]), .ifmap_g2b_xbcast(gb[0]), .ifmap_g2b_ready(if_gr),
    .ifmap_b2m_valid(if_bv), .ifmap_b2m_data(if_bd), .ifmap_b2m_col_en(if_bc),
    .ifmap_b2m_ready(br[0]),
    .fltr_g2b_valid(gv[1]), .fltr_g2b_data(gd[1][15:0]), .fltr_g2b_ytag(gy[1]),
    .fltr_g2b_xid(gx[1]), .fltr_g2b_xbcast(gb[1]), .fltr_g2b_ready(fl_gr),
    .fltr_b2m_valid(fl_bv), .fltr_b2m_data(fl_bd), .fltr_b2m_col_en(fl_bc),
    .fltr_b2m_ready(br[1]),
    .psum_g2b_valid(gv[2]), .psum_g2b_data(gd[2]), .psum_g2b_ytag(gy[2]),
    .psum_g2b_xid(gx[2]), .psum_g2b_xbcast(gb[2]), .psum_g2b_ready(ps_gr),
    .psum_b2m_valid(ps_bv), .psum_b2m_data(ps_bd), .psum_b2m_col_en(ps_bc),
    .psum_b2m_ready(br[2])
  );

  always #5 clk = ~clk;

  always_comb begin
    gr[0] = if_gr;  gr[1] = fl_gr;  gr[2] = ps_gr;
    bv[0] = if_bv;  bv[1] = fl_bv;  bv[2] = ps_bv;
    bd[0] = {16'h0, if_bd};  bd[1] = {16'h0, fl_bd};  bd[2] = ps_bd;
    bc[0] = if_bc;  bc[1] = fl_bc;  bc[2] = ps_bc;
  end

  function automatic int qsize(input int ch);
    case (ch)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ent_t qhead(input int ch);
    case (ch)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void qpush(input int ch, input ent_t e);
    case (ch)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic void qpop(input int ch);
    case (ch)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void qclear();
    q0.delete();
    q1.delete();
    q2.delete();
  endfunction

  function automatic logic [NC-1:0] exp_col(input logic b, input logic [XW-1:0] x);
    return b ? '1 : NC'(1 << x);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic v, input logic [YW-1:0] y,
                               input logic [XW-1:0] x, input logic b, input logic [31:0] d);
    gv[ch] = v;  gy[ch] = y;  gx[ch] = x;  gb[ch] = b;  gd[ch] = d;
  endtask

  task automatic idle();
    for (int ch = 0; ch < 3; ch++) applyStimulus(ch, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " rst_busy"}, 64'(rst_busy), 64'd1);
    checkOutput({tag, " kernel_size_o"}, 64'(kernel_size_o), 64'd0);
    for (int ch = 0; ch < 3; ch++) begin
      checkOutput({tag, " ", chn[ch], "_g2b_ready"}, 64'(gr[ch]), 64'd0);
      checkOutput({tag, " ", chn[ch], "_b2m_valid"}, 64'(bv[ch]), 64'd0);
      checkOutput({tag, " ", chn[ch], "_b2m_data"}, 64'(bd[ch]), 64'd0);
      checkOutput({tag, " ", chn[ch], "_b2m_col_en"}, 64'(bc[ch]), 64'd0);
    end
  endtask

  task automatic doFlush(input logic [YW-1:0] r, input logic [7:0] k);
    cfg_row_id = r;  kernel_size = k;  row = r;  flush = 1'b1;
    step();
    flush = 1'b0;  cfg_row_id = ~r;  kernel_size = ~k;
  endtask

  // Predictor: checks ingress readiness and configuration, queues accepted words.
  initial begin
    bit   push_pend [3];
    ent_t push_ent  [3];
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < 3; ch++) push_pend[ch] = 1'b0;
      if (rstn) begin
        checkOutput("rst_busy", 64'(rst_busy), 64'(!m_run));
        checkOutput("kernel_size_o", 64'(kernel_size_o), 64'(m_kernel));
        for (int ch = 0; ch < 3; ch++) begin
          bit match, rdy;
          match = gv[ch] && (gy[ch] == m_row);
          rdy   = m_run && (!match || qsize(ch) < DEPTH);
          checkOutput({chn[ch], "_g2b_ready"}, 64'(gr[ch]), 64'(rdy));
          push_pend[ch] = match && rdy;
          push_ent[ch]  = {(ch == 2) ? gd[ch] : {16'h0, gd[ch][15:0]}, exp_col(gb[ch], gx[ch])};
        end
      end
      @(posedge clk);
      if (!rstn) begin
        qclear();
        m_run = 0;  m_left = 0;  m_row = '0;  m_kernel = '0;
      end else if (flush) begin
        qclear();
        m_run = 0;  m_left = 2;  m_row = cfg_row_id;  m_kernel = kernel_size;
      end else begin
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_run = 1;
        end
        for (int ch = 0; ch < 3; ch++) if (push_pend[ch]) qpush(ch, push_ent[ch]);
      end
    end
  end

  // Monitor: compares the delivered head against the scoreboard and retires it on delivery.
  initial begin
    bit pop_pend [3];
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < 3; ch++) pop_pend[ch] = 1'b0;
      if (rstn) begin
        for (int ch = 0; ch < 3; ch++) begin
          bit   ev;
          ent_t e;
          ev = qsize(ch) > 0;
          checkOutput({chn[ch], "_b2m_valid"}, 64'(bv[ch]), 64'(ev));
          if (ev && bv[ch] === 1'b1) begin
            e = qhead(ch);
            checkOutput({chn[ch], "_b2m_data"}, 64'(bd[ch]), 64'(e[35:4]));
            checkOutput({chn[ch], "_b2m_col_en"}, 64'(bc[ch]), 64'(e[3:0]));
            pop_pend[ch] = &(~e[3:0] | br[ch]);
          end
        end
      end
      @(posedge clk);
      if (rstn && !flush)
        for (int ch = 0; ch < 3; ch++) if (pop_pend[ch]) qpop(ch);
    end
  end

  initial begin
    idle();
    for (int ch = 0; ch < 3; ch++) br[ch] = '1;
    #2 rstn = 1'b0;
    #1 checkReset("por");
    repeat (3) step();
    rstn = 1'b1;

    // unconfigured: a transaction for the reset row id must be refused
    applyStimulus(0, 1'b1, 2'd0, 2'd0, 1'b0, 32'h1111);
    step();  step();  idle();

    doFlush(2'd2, 8'd3);
    applyStimulus(0, 1'b1, 2'd2, 2'd1, 1'b0, 32'h5555);
    step();  step();  idle();

    applyStimulus(0, 1'b1, 2'd2, 2'd1, 1'b0, 32'h1234);
    step();  idle();  step();

    applyStimulus(0, 1'b1, 2'd1, 2'd2, 1'b0, 32'hBEEF);
    step();  idle();  step();

    br[2] = 4'b1011;
    applyStimulus(2, 1'b1, 2'd2, 2'd0, 1'b1, 32'hDEADBEEF);
    step();  idle();
    repeat (3) step();
    br[2] = 4'hF;
    step();  step();

    // fltr back-pressured while ifmap and psum keep flowing
    br[1] = '0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 1'b1, 2'd2, 2'(i), 1'b0, 32'(i));
      applyStimulus(0, 1'b1, 2'd2, 2'(i + 1), 1'b0, 32'(16'hA000 + i));
      applyStimulus(2, 1'b1, 2'd2, 2'(i + 2), 1'b0, 32'hC0DE0000 + 32'(i));
      step();
    end
    idle();  step();
    br[1] = '1;
    repeat (6) step();

    br[0] = '0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b1, 2'd2, 2'(i), 1'b0, 32'(16'h7700 + i));
      step();
    end
    idle();  step();
    doFlush(2'd2, 8'd3);
    repeat (4) step();
    br[0] = '1;
    repeat (3) step();

    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int ch = 0; ch < 3; ch++) begin
        logic [YW-1:0] y;
        y = ($urandom_range(0, 3) == 0) ? YW'($urandom_range(0, NR - 1)) : row;
        applyStimulus(ch, $urandom_range(0, 9) < 7, y, XW'($urandom_range(0, NC - 1)),
                      $urandom_range(0, 3) == 0, $urandom);
        br[ch] = ($urandom_range(0, 3) == 0) ? NC'($urandom) : NC'($urandom | $urandom);
      end
      if (cyc == 250 || cyc == 401) begin
        doFlush(YW'($urandom_range(0, NR - 1)), 8'($urandom));
      end else if (cyc == 400) begin
        #2 rstn = 1'b0;
        #1 checkReset("midrun");
        step();  step();
        rstn = 1'b1;
      end else begin
        step();
      end
    end

    idle();
    for (int ch = 0; ch < 3; ch++) br[ch] = '1;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
